// File: rtl/bvh_update_scheduler_if.sv
// Command/completion bus between the BVH update scheduler and the build/refit kernel dispatcher.
interface bvh_update_scheduler_if #(
  parameter int NCH = 4
) ();
  localparam int IDW = $clog2(NCH);

  logic           cmd_valid;
  logic           cmd_ready;
  logic [IDW-1:0] cmd_ch;
  logic           cmd_rebuild;
  logic           done_valid;
  logic [IDW-1:0] done_ch;

  modport master (
    output cmd_valid, cmd_ch, cmd_rebuild,
    input  cmd_ready, done_valid, done_ch
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_rebuild,
    output cmd_ready, done_valid, done_ch
  );
endinterface

// File: rtl/bvh_update_scheduler.sv
// Per-BLAS refit/rebuild scheduler: tracks change and refit counts per channel and
// issues one command per cycle max to the kernel dispatcher with round-robin grant.
module bvh_update_ch #(
  parameter int CNT_W     = 8,
  parameter int REFIT_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chg,
  input  logic             load,
  input  logic             hs,
  input  logic             hs_rebuild,
  input  logic             done,
  input  logic             high_ray_load,
  input  logic [CNT_W-1:0] thresh,
  output logic             is_pend,
  output logic             rebuild_req,
  output logic             pending,
  output logic             busy
);
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_OFFER, S_FLIGHT} st_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] RMAX    = CNT_W'(REFIT_MAX);

  st_t              st;
  logic [CNT_W-1:0] chg_cnt;
  logic [CNT_W-1:0] refit_cnt;
  logic             dirty;

  assign is_pend     = (st == S_PEND);
  assign rebuild_req = ((chg_cnt >= thresh) && high_ray_load) || (refit_cnt >= RMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      chg_cnt   <= '0;
      refit_cnt <= '0;
      dirty     <= 1'b0;
      pending   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // A change landing on the rebuild handshake counts after the clear.
      if (hs && hs_rebuild)
        chg_cnt <= {{(CNT_W-1){1'b0}}, chg};
      else if (chg && chg_cnt != CNT_MAX)
        chg_cnt <= chg_cnt + CNT_W'(1);

      if (hs) begin
        if (hs_rebuild)
          refit_cnt <= '0;
        else if (refit_cnt != CNT_MAX)
          refit_cnt <= refit_cnt + CNT_W'(1);
      end

      case (st)
        S_IDLE: if (chg) begin
          st      <= S_PEND;
          pending <= 1'b1;
        end
        S_PEND: if (load) st <= S_OFFER;
        S_OFFER: begin
          if (chg) dirty <= 1'b1;
          if (hs) begin
            st      <= S_FLIGHT;
            pending <= 1'b0;
            busy    <= 1'b1;
          end
        end
        S_FLIGHT: begin
          if (done) begin
            dirty <= 1'b0;
            busy  <= 1'b0;
            if (dirty || chg) begin
              st      <= S_PEND;
              pending <= 1'b1;
            end else begin
              st <= S_IDLE;
            end
          end else if (chg) begin
            dirty <= 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

module bvh_update_scheduler #(
  parameter int NCH       = 4,
  parameter int CNT_W     = 8,
  parameter int REFIT_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        scene_change,
  input  logic                  high_ray_load,
  input  logic [CNT_W-1:0]      thresh,
  bvh_update_scheduler_if.master cif,
  output logic [NCH-1:0]        busy,
  output logic [NCH-1:0]        pending,
  output logic                  err
);
  localparam int IDW = $clog2(NCH);

  logic [IDW-1:0] rr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] grant_nxt;
  logic [IDW:0]   idx;
  logic           found;
  logic           can_load;
  logic           hs;
  logic [NCH-1:0] pend_v;
  logic [NCH-1:0] rb_req;
  logic [NCH-1:0] load_v;
  logic [NCH-1:0] hs_v;
  logic [NCH-1:0] done_v;

  assign hs       = cif.cmd_valid && cif.cmd_ready;
  assign can_load = !cif.cmd_valid || cif.cmd_ready;

  // First PEND channel at or after rr, wrapping mod NCH.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = {1'b0, rr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NCH)) idx = idx - (IDW+1)'(NCH);
      if (!found && pend_v[idx[IDW-1:0]]) begin
        found = 1'b1;
        grant = idx[IDW-1:0];
      end
    end
  end

  assign grant_nxt = (grant == IDW'(NCH-1)) ? '0 : grant + IDW'(1);

  for (genvar i = 0; i < NCH; i++) begin : g_sel
    assign load_v[i] = can_load && found && (grant == IDW'(i));
    assign hs_v[i]   = hs && (cif.cmd_ch == IDW'(i));
    assign done_v[i] = cif.done_valid && (cif.done_ch == IDW'(i));
  end

  bvh_update_ch #(.CNT_W(CNT_W), .REFIT_MAX(REFIT_MAX)) u_ch [NCH-1:0] (
    .clk           (clk),
    .rst_n         (rst_n),
    .chg           (scene_change),
    .load          (load_v),
    .hs            (hs_v),
    .hs_rebuild    (cif.cmd_rebuild),
    .done          (done_v),
    .high_ray_load (high_ray_load),
    .thresh        (thresh),
    .is_pend       (pend_v),
    .rebuild_req   (rb_req),
    .pending       (pending),
    .busy          (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr              <= '0;
      cif.cmd_valid   <= 1'b0;
      cif.cmd_ch      <= '0;
      cif.cmd_rebuild <= 1'b0;
      err             <= 1'b0;
    end else begin
      // done_ch out of range matches no channel, so it also flags.
      err <= cif.done_valid && !(|(done_v & busy));
      if (can_load) begin
        cif.cmd_valid <= found;
        if (found) begin
          cif.cmd_ch      <= grant;
          cif.cmd_rebuild <= rb_req[grant];
          rr              <= grant_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_bvh_update_scheduler.sv
// Scoreboard bench: a per-edge behavioural model queues expected commands; a monitor
// checks outputs every cycle and pops the queue on each handshake.
module tb_bvh_update_scheduler;
  localparam int NCH       = 4;
  localparam int CNT_W     = 8;
  localparam int REFIT_MAX = 8;
  localparam int IDW       = $clog2(NCH);
  localparam int CMAX      = (1 << CNT_W) - 1;
  localparam int M_IDLE = 0, M_PEND = 1, M_OFFER = 2, M_FLIGHT = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   sc = '0;
  logic             hrl = 1'b0;
  logic [CNT_W-1:0] th = CNT_W'(4);
  logic [NCH-1:0]   busy, pending;
  logic             err;

  bvh_update_scheduler_if #(.NCH(NCH)) cif ();

  bvh_update_scheduler #(.NCH(NCH), .CNT_W(CNT_W), .REFIT_MAX(REFIT_MAX)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .scene_change  (sc),
    .high_ray_load (hrl),
    .thresh        (th),
    .cif           (cif),
    .busy          (busy),
    .pending       (pending),
    .err           (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [IDW-1:0] ch; logic rb; } exp_t;
  exp_t q[$];
  int   m_st[NCH];
  int   m_cnt[NCH];
  int   m_rf[NCH];
  bit   m_dirty[NCH];
  bit   m_valid, m_rb, m_err;
  int   m_ch, m_rr;

  function automatic void m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_st[i] = M_IDLE; m_cnt[i] = 0; m_rf[i] = 0; m_dirty[i] = 0;
    end
    m_valid = 0; m_rb = 0; m_err = 0; m_ch = 0; m_rr = 0;
    q.delete();
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_edge();
    int  os[NCH];
    bit  hs, dv, rb, can;
    int  g, dch;
    hs  = m_valid && cif.cmd_ready;
    can = !m_valid || cif.cmd_ready;
    dv  = cif.done_valid;
    dch = int'(cif.done_ch);
    m_err = dv && !(dch < NCH && m_st[dch] == M_FLIGHT);
    g = -1;
    if (can)
      for (int k = 0; k < NCH; k++)
        if (g < 0 && m_st[(m_rr + k) % NCH] == M_PEND) g = (m_rr + k) % NCH;
    rb = 0;
    if (g >= 0) rb = (m_cnt[g] >= int'(th) && hrl) || m_rf[g] >= REFIT_MAX;
    for (int i = 0; i < NCH; i++) os[i] = m_st[i];
    for (int i = 0; i < NCH; i++) begin
      case (os[i])
        M_IDLE:  if (sc[i]) m_st[i] = M_PEND;
        M_PEND:  if (i == g) m_st[i] = M_OFFER;
        M_OFFER: begin
          if (sc[i]) m_dirty[i] = 1;
          if (hs) begin
            m_st[i] = M_FLIGHT;
            if (m_rb) begin m_cnt[i] = 0; m_rf[i] = 0; end
            else m_rf[i] = sat(m_rf[i] + 1);
          end
        end
        default: begin
          if (dv && dch == i) begin
            m_st[i] = (m_dirty[i] || sc[i]) ? M_PEND : M_IDLE;
            m_dirty[i] = 0;
          end else if (sc[i]) m_dirty[i] = 1;
        end
      endcase
      if (sc[i]) m_cnt[i] = sat(m_cnt[i] + 1);
    end
    if (can) begin
      if (g >= 0) begin
        m_valid = 1; m_ch = g; m_rb = rb; m_rr = (g + 1) % NCH;
        q.push_back('{ch: IDW'(g), rb: rb});
      end else m_valid = 0;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else model_edge();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      logic [NCH-1:0] ep, eb;
      @(negedge clk); #1;
      for (int i = 0; i < NCH; i++) begin
        ep[i] = (m_st[i] == M_PEND || m_st[i] == M_OFFER);
        eb[i] = (m_st[i] == M_FLIGHT);
      end
      chk("pending", int'(pending), int'(ep));
      chk("busy", int'(busy), int'(eb));
      chk("err", int'(err), int'(m_err));
      chk("cmd_valid", int'(cif.cmd_valid), int'(m_valid));
      if (cif.cmd_valid) begin
        if (q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          chk("cmd_ch", int'(cif.cmd_ch), int'(q[0].ch));
          chk("cmd_rebuild", int'(cif.cmd_rebuild), int'(q[0].rb));
          if (cif.cmd_ready) void'(q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [NCH-1:0] s, input logic h, input logic r,
                      input logic d, input int dc);
    @(negedge clk);
    sc = s; hrl = h; cif.cmd_ready = r; cif.done_valid = d; cif.done_ch = IDW'(dc);
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, hrl, 1'b1, 1'b0, 0);
  endtask

  // Wait (bounded) for ch to be in flight, then complete it.
  task automatic svc(input int ch);
    for (int k = 0; k < 20 && m_st[ch] != M_FLIGHT; k++) step('0, hrl, 1'b1, 1'b0, 0);
    chk("reach_flight", int'(busy[ch]), 1);
    step('0, hrl, 1'b1, 1'b1, ch);
  endtask

  task automatic rand_phase(input int n);
    for (int c = 0; c < n; c++) begin
      logic [NCH-1:0] s;
      logic d, r;
      int dc, j;
      s = '0;
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 9) == 0) s[i] = 1'b1;
      if (c % 500 == 0) th = CNT_W'($urandom_range(0, 12));
      r = ($urandom_range(0, 9) < 7);
      d = 1'b0; dc = 0;
      j = $urandom_range(0, NCH - 1);
      if ($urandom_range(0, 2) == 0 && m_st[j] == M_FLIGHT) begin d = 1'b1; dc = j; end
      if ($urandom_range(0, 49) == 0) begin d = 1'b1; dc = $urandom_range(0, NCH - 1); end
      step(s, 1'($urandom_range(0, 1)), r, d, dc);
    end
  endtask

  initial begin
    cif.cmd_ready = 1'b0; cif.done_valid = 1'b0; cif.done_ch = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_valid", int'(cif.cmd_valid), 0);
    chk("rst_cmd_ch", int'(cif.cmd_ch), 0);
    chk("rst_cmd_rebuild", int'(cif.cmd_rebuild), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;

    // single request on ch2
    step(4'b0100, 1'b0, 1'b1, 1'b0, 0);
    svc(2); idle(2);

    // ch1: four refits, then rebuild under heavy load, then a refit again
    repeat (4) begin step(4'b0010, 1'b0, 1'b1, 1'b0, 0); svc(1); idle(1); end
    step(4'b0010, 1'b1, 1'b1, 1'b0, 0); svc(1); idle(1);
    step(4'b0010, 1'b0, 1'b1, 1'b0, 0); svc(1); idle(1);

    // REFIT_MAX forces the ninth command on ch0 to rebuild
    th = CNT_W'(200);
    repeat (9) begin step(4'b0001, 1'b0, 1'b1, 1'b0, 0); svc(0); idle(1); end

    // park rr at 0, then all channels at once, then ch3+ch0
    th = CNT_W'(4);
    step(4'b1000, 1'b0, 1'b1, 1'b0, 0); svc(3); idle(1);
    step(4'b1111, 1'b0, 1'b1, 1'b0, 0); idle(6);
    for (int i = 0; i < NCH; i++) svc(i);
    idle(1);
    step(4'b1001, 1'b0, 1'b1, 1'b0, 0); svc(0); svc(3); idle(2);

    // stalled offer with toggling load hint and a change on the offered channel
    step(4'b0010, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 1; k <= 6; k++) step((k == 3) ? 4'b0010 : 4'b0000, 1'(k & 1), 1'b0, 1'b0, 0);
    svc(1); svc(1); idle(2);

    // done for an idle channel
    step('0, 1'b0, 1'b1, 1'b1, 3); idle(3);

    rand_phase(3000);
    idle(4);
    for (int k = 0; k < 400; k++) begin
      int f;
      f = -1;
      for (int i = 0; i < NCH; i++) if (f < 0 && m_st[i] == M_FLIGHT) f = i;
      if (f < 0 && !m_valid && pending == '0) break;
      step('0, 1'b0, 1'b1, f >= 0, (f >= 0) ? f : 0);
    end

    // reset mid-flight, then a late done
    th = CNT_W'(4);
    step(4'b0100, 1'b0, 1'b1, 1'b0, 0);
    for (int k = 0; k < 20 && m_st[2] != M_FLIGHT; k++) step('0, 1'b0, 1'b1, 1'b0, 0);
    chk("pre_rst_busy2", int'(busy[2]), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cmd_valid", int'(cif.cmd_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pending", int'(pending), 0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    step('0, 1'b0, 1'b1, 1'b1, 2);
    idle(3);

    chk("end_idle", int'(busy | pending), 0);
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bvh_update_scheduler.md
Name: bvh_update_scheduler

Overview:
- Multi-channel BVH maintenance scheduler: one channel per BLAS (bottom-level acceleration structure).
- Per channel, it tracks geometry-change frequency and refits issued since the last rebuild.
- Chooses refit vs full rebuild per request and issues commands to the build/refit kernel dispatcher over a valid/ready interface; completion returns on a done port.
- Sits between the scene-change detectors and the dispatcher in the ray-tracing acceleration-structure pipeline.

Parameters:
- NCH, 4, number of BLAS channels (>=2).
- CNT_W, 8, width of the change counter, refit counter and thresh port.
- REFIT_MAX, 8, refits since last rebuild that force a rebuild regardless of load (1..2^CNT_W-1).
- IDW, $clog2(NCH), channel-index width (localparam).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- scene_change  in  NCH  per-channel change strobe, 1-cycle pulses
- high_ray_load  in  1  heavy-traversal hint
- thresh  in  CNT_W  change-count rebuild threshold, quasi-static
- cmd_valid  out  1  command offered
- cmd_ready  in  1  dispatcher accepts command
- cmd_ch  out  IDW  channel of offered command
- cmd_rebuild  out  1  1=full rebuild, 0=refit
- done_valid  in  1  kernel completion strobe
- done_ch  in  IDW  channel completed
- busy  out  NCH  channel kernel in flight
- pending  out  NCH  channel awaiting issue (includes offered-not-accepted)
- err  out  1  1-cycle pulse: done for a channel not in flight

Behaviour:
- Reset (async): every channel IDLE; chg_cnt=0, refit_cnt=0, dirty=0; rr pointer=0; cmd_valid=0, cmd_ch=0, cmd_rebuild=0, busy=0, pending=0, err=0. Reset mid-operation discards in-flight state; late done_valid after reset produces err.
- Per-channel states: IDLE, PEND, OFFER (loaded on cmd bus), FLIGHT. pending=PEND|OFFER, busy=FLIGHT; both registered.
- scene_change[i] in any state: chg_cnt[i]+=1, saturating at 2^CNT_W-1.
  - IDLE -> PEND on the next edge.
  - In OFFER or FLIGHT, sets dirty[i].
  - In PEND, only counts (requests merge).
- Offer load happens at an edge where (!cmd_valid || cmd_ready) and some channel is PEND (excluding a channel handshaking this cycle).
  - Grant is round-robin: first PEND channel at or after the rr pointer, wrapping mod NCH; rr pointer <- grant+1 mod NCH.
  - cmd_ch <- grant; cmd_valid <- 1.
  - cmd_rebuild <- (chg_cnt>=thresh && high_ray_load) || refit_cnt>=REFIT_MAX, evaluated from current registered counts. thresh=0 therefore rebuilds whenever high_ray_load=1.
  - Granted channel PEND -> OFFER.
- Offer stability: cmd_valid, cmd_ch and cmd_rebuild hold while cmd_valid && !cmd_ready, even if counts or high_ray_load change.
- If no load occurs on a handshake edge, cmd_valid -> 0.
- Back-to-back: a handshake edge may load the next offer in the same edge, giving one command per cycle max.
- Handshake (cmd_valid && cmd_ready): channel OFFER -> FLIGHT.
  - Rebuild: chg_cnt and refit_cnt <- 0.
  - Refit: refit_cnt+=1, saturating; chg_cnt unchanged.
  - A scene_change to the same channel on the same edge applies after the clear (rebuild leaves chg_cnt=1) and sets dirty.
- done_valid with done_ch in FLIGHT: -> PEND if dirty or scene_change same cycle, else -> IDLE; dirty cleared.
- done_valid with done_ch not in FLIGHT, or done_ch>=NCH: state unchanged; err=1 on the next cycle.
- Latency: scene_change at edge t -> pending at t+1 -> cmd_valid at t+2 if the bus is free.
- Simultaneous events on different channels are independent. A done and a new offer may occur on the same edge.

Test Plan:
- Reset, scene_change[2] pulse at t, cmd_ready=1, thresh=4 -> pending[2]=1 at t+1; cmd_valid=1, cmd_ch=2, cmd_rebuild=0 at t+2; busy[2]=1 at t+3; done_ch=2 -> busy[2]=0, IDLE.
- Channel 1: 4 change/refit/done cycles, then a 5th change with high_ray_load=1, thresh=4 -> chg_cnt=5>=4 -> cmd_rebuild=1; after handshake chg_cnt=0, refit_cnt=0. Repeat with high_ray_load=0 -> refit.
- REFIT_MAX=8, high_ray_load=0: 8 refits on ch0 -> 9th command cmd_rebuild=1.
- scene_change on all 4 channels same cycle, cmd_ready=1 -> commands ch0,1,2,3 on consecutive cycles. Then ch3 and ch0 pend with rr pointer=0 -> order ch0, ch3.
- cmd_ready=0 for 5 cycles with high_ray_load toggling -> cmd_ch/cmd_rebuild stable. scene_change on offered channel -> after done it returns to PEND and reissues.
- done_ch=3 while ch3 IDLE -> err pulse 1 cycle, no state change. Assert rst_n mid-FLIGHT -> all outputs 0 immediately.
